// File: rtl/reverb_delay_tap.sv
// -----------------------------------------------------------------------------
// reverb_delay_tap
//
// Circular-buffer delay line feeding the reverb add/sub mixer. For each accepted
// sample it emits an aligned pair two cycles later:
//   dry_out - the sample itself
//   wet_out - the sample accepted delay_len valid samples earlier (0 until the
//             buffer holds that many samples)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   i_in_sample valid this cycle (full rate supported)
//   i_in_sample  input sample, two's complement, passed through untouched
//   i_delay_len  tap distance in valid samples, sampled with each accepted sample
//   i_clear      synchronous flush of pointers, fill state and in-flight samples
//   o_out_valid  one-cycle pulse per output pair
//   o_dry_out    delayed-aligned copy of the input sample (holds between pulses)
//   o_wet_out    tapped sample or 0 (holds between pulses)
//   o_fill_done  registered (fill_cnt >= i_delay_len)
// -----------------------------------------------------------------------------
module reverb_delay_tap #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_sample,
    input  logic [ADDR_W-1:0] i_delay_len,
    input  logic              i_clear,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_dry_out,
    output logic [DATA_W-1:0] o_wet_out,
    output logic              o_fill_done
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Sample buffer; deliberately not reset, stale words are masked by fill_cnt.
    logic [DATA_W-1:0] r_mem [Depth];
    logic [DATA_W-1:0] r_rd_data;

    // Write pointer and count of valid samples written (saturating).
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;

    // Stage 1: accepted sample waiting for the synchronous RAM read.
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_sample;
    logic              r_s1_avail;
    logic              r_s1_bypass;

    // Stage 2: registered outputs.
    logic              r_out_valid;
    logic [DATA_W-1:0] r_dry_out;
    logic [DATA_W-1:0] r_wet_out;
    logic              r_fill_done;

    logic              w_accept;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_tap_avail;
    logic              w_fill_max;
    logic [DATA_W-1:0] w_wet_next;

    // clear wins over a simultaneous valid: that sample is dropped.
    assign w_accept    = i_in_valid & ~i_clear;
    // Unsigned subtraction wraps modulo the buffer depth.
    assign w_rd_addr   = r_wr_ptr - i_delay_len;
    assign w_tap_avail = (r_fill_cnt >= i_delay_len);
    assign w_fill_max  = (r_fill_cnt == {ADDR_W{1'b1}});

    // Read-before-write RAM: a read of the address being written returns the
    // old word, so delay_len == 0 is served by the bypass mux below.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_in_sample;
            r_rd_data       <= r_mem[w_rd_addr];
        end
    end

    // Pointer, fill state and stage 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_avail  <= 1'b0;
            r_s1_bypass <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                if (!w_fill_max) begin
                    r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
                end
                r_s1_sample <= i_in_sample;
                r_s1_avail  <= w_tap_avail;
                r_s1_bypass <= (i_delay_len == '0);
            end
        end
    end

    always_comb begin
        w_wet_next = '0;
        if (r_s1_avail) begin
            w_wet_next = r_s1_bypass ? r_s1_sample : r_rd_data;
        end
    end

    // Output stage; data holds between pulses and across clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_dry_out   <= '0;
            r_wet_out   <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= w_tap_avail;
            if (i_clear) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_dry_out <= r_s1_sample;
                    r_wet_out <= w_wet_next;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_dry_out   = r_dry_out;
    assign o_wet_out   = r_wet_out;
    assign o_fill_done = r_fill_done;

endmodule

// File: doc/reverb_delay_tap.md
Name: reverb_delay_tap

Overview:
Circular-buffer delay line that sits directly upstream of the reverb add/sub mixer. Per input sample it produces an aligned pair:
- dry_out: the current sample.
- wet_out: the sample from delay_len valid samples earlier.
The mixer sums or differences the pair to build echo/comb taps. Buffering is a single-port-write, synchronous-read RAM addressed modulo 2^ADDR_W.

Parameters:
DATA_W, 32, sample width (matches mixer operand width)
ADDR_W, 10, buffer address width; depth = 2^ADDR_W, max delay = 2^ADDR_W-1 samples

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  in_sample valid this cycle; may be high every cycle
in_sample  input  DATA_W  input audio sample, two's complement
delay_len  input  ADDR_W  tap distance in samples, sampled on each in_valid
clear  input  1  synchronous flush of pointers and fill state
out_valid  output  1  dry_out/wet_out valid this cycle (single-cycle pulse per sample)
dry_out  output  DATA_W  delayed-aligned copy of in_sample
wet_out  output  DATA_W  sample written delay_len samples before, or 0 if not yet available
fill_done  output  1  high when fill_cnt >= current delay_len

Behaviour:
- Reset (reset_n low, async):
  - wr_ptr=0, fill_cnt=0; pipeline valids=0.
  - out_valid=0, dry_out=0, wet_out=0, fill_done=0 (delay_len=0 makes fill_done=1 one cycle after release).
  - RAM contents are not reset; stale data is masked by fill_cnt.
- Accept, cycle N with in_valid=1 and clear=0:
  - Write in_sample at wr_ptr.
  - Read address rd_addr = (wr_ptr - delay_len) mod 2^ADDR_W, unsigned wrap.
  - Latch in_sample, delay_len, and the tap-available flag (fill_cnt >= delay_len) into stage 1.
  - wr_ptr increments with wrap 2^ADDR_W-1 -> 0.
  - fill_cnt increments, saturating at 2^ADDR_W-1.
- Latency is fixed at 2 cycles: out_valid pulses at N+2.
  - dry_out = sample of cycle N.
  - wet_out = RAM read data if tap-available, else 0.
  - Outputs hold their value when out_valid=0.
- delay_len=0: the read address equals the write address. wet_out must equal the same cycle's in_sample, via a write-first bypass mux; it must not return the old RAM word.
- Back-to-back in_valid is supported at full rate with no bubbles. Gaps in in_valid stall pointers; delay counts valid samples, not cycles.
- delay_len change takes effect on the next accepted sample. Increasing delay_len beyond fill_cnt forces wet_out=0 until enough samples have been written. Decreasing delay_len takes effect immediately.
- fill_done is registered: it updates each cycle from fill_cnt and delay_len.
- clear:
  - Next cycle: wr_ptr=0, fill_cnt=0, pipeline valids killed, so no out_valid for samples in flight.
  - clear has priority over a simultaneous in_valid; that sample is dropped.
  - dry_out/wet_out retain their last values.
- Reset asserted mid-stream: all in-flight samples are discarded and outputs return to reset values immediately.
- Signed data is passed through untouched; no arithmetic on sample values.

Test Plan:
- ADDR_W=4, delay_len=3, in_valid continuous, samples 1,2,3,... -> out_valid from cycle 2 onward; wet_out = 0,0,0,1,2,3... paired with dry_out = 1,2,3,4,5,6...; fill_done rises after 3rd sample.
- ADDR_W=4, delay_len=15, feed 40 samples 100..139 -> wet_out = dry_out-15 once filled; correct across wr_ptr wrap 15->0; fill_cnt saturates at 15.
- delay_len=0, samples 0xDEADBEEF then 0x00000005 -> wet_out equals dry_out each sample (bypass check), 2-cycle latency.
- in_valid pattern 1,0,0,1,0,1 with samples A,B,C, delay_len=1 -> three out_valid pulses; wet_out = 0,A,B; no pulses during gaps.
- After 10 samples with delay_len=4, assert clear together with in_valid (sample 0x77) -> sample 0x77 dropped, no out_valid for the 2 in-flight samples; next 4 outputs have wet_out=0.
- Assert reset_n low for 1 cycle mid-stream -> out_valid/dry_out/wet_out/fill_done go 0 asynchronously; resumed stream behaves as from power-up.
